// File: rtl/comp_bist_ctrl.sv
// comp_bist_ctrl: exhaustive BIST sequencer for a WIDTH-bit equality comparator
module comp_bist_ctrl #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               Q,
   output logic [WIDTH-1:0]   A,
   output logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic [WIDTH-1:0]   fail_A,
   output logic [WIDTH-1:0]   fail_B
);
   localparam int CW = $clog2(SETTLE) + 1;
   typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] idx_q, idx_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, fa_q, fa_d, fb_q, fb_d;
   logic [2*WIDTH:0]   err_q, err_d;
   logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d, ff_q, ff_d;
   logic               mism;
   // X/Z on Q never equals a driven 0/1, so it counts as a mismatch
   assign mism = (Q !== (a_q == b_q));
   // state and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         fa_q    <= '0;
         fb_q    <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         ff_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         ff_q    <= ff_d;
      end
   end
   // sequencing: start, settle, check each vector, finish after the last one
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      ff_d    = ff_q;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = WAIT;
            idx_d   = '0;
            a_d     = '0;
            b_d     = '0;
            fa_d    = '0;
            fb_d    = '0;
            err_d   = '0;
            ff_d    = 1'b0;
            cnt_d   = CW'(SETTLE - 1);
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
         WAIT: begin
            state_d = (cnt_q == '0) ? CHECK : WAIT;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
         end
         CHECK: begin
            err_d = err_q + {{(2*WIDTH){1'b0}}, mism};
            if (mism && !ff_q) begin
               fa_d = a_q;
               fb_d = b_q;
               ff_d = 1'b1;
            end
            if (&idx_q) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d = WAIT;
               idx_d   = idx_q + (2*WIDTH)'(1);
               a_d     = idx_d[WIDTH-1:0];
               b_d     = idx_d[2*WIDTH-1:WIDTH];
               cnt_d   = CW'(SETTLE - 1);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign A         = a_q;
   assign B         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_A    = fa_q;
   assign fail_B    = fb_q;
endmodule

// File: tb/tb_comp_bist_ctrl.sv
// tb_comp_bist_ctrl: directed runs of comp_bist_ctrl against a per-cycle reference model
module tb_comp_bist_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic start1, start3;
   logic q1, q3;
   logic [3:0] a1, b1, fa1, fb1, a3, b3, fa3, fb3;
   logic busy1, done1, pass1, busy3, done3, pass3;
   logic [8:0] err1, err3;
   int mode, sel, n, passed, total;
   bit track;
   always #5 clk = ~clk;

   comp_bist_ctrl #(.WIDTH(4), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .Q(q1), .A(a1), .B(b1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_A(fa1), .fail_B(fb1));
   comp_bist_ctrl #(.WIDTH(4), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .Q(q3), .A(a3), .B(b3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .fail_A(fa3), .fail_B(fb3));

   // comparator behaviour: 0 golden, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
   function automatic logic qf(input int m, input logic [3:0] a, input logic [3:0] b);
      return (m == 0) ? (a == b) : (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : (a != b);
   endfunction
   assign q1 = qf(mode, a1, b1);
   assign q3 = qf(mode, a3, b3);

   logic        dbusy, ddone, dpass;
   logic [8:0]  derr;
   logic [3:0]  da, db, dfa, dfb;
   assign dbusy = sel ? busy3 : busy1;
   assign ddone = sel ? done3 : done1;
   assign dpass = sel ? pass3 : pass1;
   assign derr  = sel ? err3  : err1;
   assign da    = sel ? a3    : a1;
   assign db    = sel ? b3    : b1;
   assign dfa   = sel ? fa3   : fa1;
   assign dfb   = sel ? fb3   : fb1;

   // expected outputs n edges after the accepting edge: vectors checked so far = n/(s+1)
   function automatic logic [27:0] model(input int nn, input int s, input int m);
      int k, err;
      logic [3:0] fa, fb;
      logic [7:0] v8, cur;
      bit first, bz;
      k = nn / (s + 1);
      if (k > 256) k = 256;
      err = 0; fa = 0; fb = 0; first = 1;
      for (int v = 0; v < k; v++) begin
         v8 = v[7:0];
         if (qf(m, v8[3:0], v8[7:4]) !== (v8[3:0] == v8[7:4])) begin
            err++;
            if (first) begin fa = v8[3:0]; fb = v8[7:4]; first = 0; end
         end
      end
      cur = (k > 255) ? 8'hFF : k[7:0];
      bz = (k < 256);
      return {bz, !bz, (!bz && err == 0), err[8:0], fa, fb, cur[3:0], cur[7:4]};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // per-cycle comparison against the model while a run is tracked
   always @(negedge clk) begin
      if (track) begin
         check($sformatf("cycle%0d", n),
               {4'h0, dbusy, ddone, dpass, derr, dfa, dfb, da, db},
               {4'h0, model(n, sel ? 3 : 1, mode)});
         n++;
      end
   end

   task automatic run(input int m, input int s, input bit extra, output int cyc, output logic [8:0] e50);
      int limit;
      mode = m; sel = s; e50 = '1;
      limit = 256 * (s ? 4 : 2) + 20;
      @(negedge clk);
      if (s) start3 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0; start3 = 1'b0;
      n = 0; track = 1; cyc = 0;
      while (cyc < limit) begin
         @(posedge clk);
         cyc++;
         #1;
         if (s) start3 = extra && (cyc == 5 || cyc == 100);
         else start1 = extra && (cyc == 5 || cyc == 100);
         if (cyc == 50) e50 = derr;
         if (ddone) break;
      end
      start1 = 1'b0; start3 = 1'b0;
      check("run_done", {31'd0, ddone}, 32'd1);
      @(negedge clk);
      #1;
      track = 0;
   endtask

   int cyc;
   logic [8:0] e50;
   initial begin
      passed = 0; total = 0; track = 0; n = 0;
      mode = 0; sel = 0; start1 = 0; start3 = 0; rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset1", {4'h0, busy1, done1, pass1, err1, fa1, fb1, a1, b1}, 32'd0);
      check("reset3", {4'h0, busy3, done3, pass3, err3, fa3, fb3, a3, b3}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // golden comparator with stray start pulses during the run
      run(0, 0, 1, cyc, e50);
      check("golden_cycles", cyc, 512);
      check("golden_res", {pass1, err1, fa1, fb1}, {1'b1, 9'd0, 4'd0, 4'd0});
      // stuck-at-0: every equal pair fails, first at idx 0
      run(1, 0, 0, cyc, e50);
      check("s0_cycles", cyc, 512);
      check("s0_res", {pass1, err1, fa1, fb1}, {1'b0, 9'd16, 4'd0, 4'd0});
      // restart from DONE with a golden comparator clears the old results
      run(0, 0, 0, cyc, e50);
      check("restart_err50", e50, 9'd0);
      check("restart_res", {pass1, err1, fa1, fb1}, {1'b1, 9'd0, 4'd0, 4'd0});
      // stuck-at-1: every unequal pair fails, first at idx 1
      run(2, 0, 0, cyc, e50);
      check("s1_res", {pass1, err1, fa1, fb1}, {1'b0, 9'd240, 4'd1, 4'd0});
      // asynchronous reset in the middle of a stuck-at-0 run
      mode = 1; sel = 0;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0; n = 0; track = 1;
      repeat (200) @(posedge clk);
      #1;
      track = 0;
      check("pre_rst_busy", {31'd0, busy1}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst", {4'h0, busy1, done1, pass1, err1, fa1, fb1, a1, b1}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(1, 0, 0, cyc, e50);
      check("post_rst_cycles", cyc, 512);
      check("post_rst_res", {pass1, err1, fa1, fb1}, {1'b0, 9'd16, 4'd0, 4'd0});
      // inverted comparator with SETTLE=3
      run(3, 1, 0, cyc, e50);
      check("inv_cycles", cyc, 1024);
      check("inv_res", {pass3, err3, fa3, fb3}, {1'b0, 9'd256, 4'd0, 4'd0});
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
